// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and the round-robin picker.
// Holds the arbiter state encoding, default bus widths and the round-robin
// pick function that the picker sub-module wraps.
package dmem_pkg;

    localparam int DMEM_ADDR_W  = 32;
    localparam int DMEM_DATA_W  = 32;

    // The pick function works on a fixed maximum requester count so it can
    // live in a package; callers zero-extend their request vector.
    localparam int RR_MAX_REQ   = 4;
    localparam int RR_IDX_MAX_W = 2;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // First requester at or after ptr (modulo n). Returns ptr when nothing
    // is requested; callers qualify the result with |req.
    function automatic logic [RR_IDX_MAX_W-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0]   req,
        input logic [RR_IDX_MAX_W-1:0] ptr,
        input int                      n
    );
        logic [RR_IDX_MAX_W-1:0] win;
        int                      j;
        win = ptr;
        // Scan farthest to nearest so the nearest requester wins last.
        for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (req[j]) win = RR_IDX_MAX_W'(j);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational round-robin picker: request vector and priority pointer in,
// one-hot grant, winner index and any-request flag out. No state; the owner
// of the pointer decides when it moves.
module dmem_rr_pick
    import dmem_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [RR_MAX_REQ-1:0]   w_req_ext;
    logic [RR_IDX_MAX_W-1:0] w_pick;

    // Widen to the package function's fixed size, pick, then decode one-hot.
    always_comb begin
        w_req_ext          = '0;
        w_req_ext[N-1:0]   = i_req;
        w_pick             = rr_pick(w_req_ext, RR_IDX_MAX_W'(i_ptr), N);
        o_idx              = IDX_W'(w_pick);
        o_any              = |i_req;
        o_gnt              = '0;
        for (int i = 0; i < N; i++) begin
            o_gnt[i] = o_any && (o_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_REQ
// requesters. One access per cycle; reads return one cycle later on rdata
// with a one-hot rvalid. A requester may lock the memory for atomic
// read-modify-write sequences.
// Optional build macro: DMEM_ARB_STATS_EN adds grant/conflict counters.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]           stat_grants,
    output logic [31:0]           stat_conflicts,
`endif
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [NUM_REQ-1:0] r_rvalid;
    logic [DATA_W-1:0]  r_rdata;

    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_acc;
    logic               w_win_we;
    logic               w_win_lock;
    logic [IDX_W-1:0]   w_ptr_nxt;

    dmem_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Select the winner: round-robin in ARB, only the owner while LOCKED.
    // Reset forces no grant so nothing reaches the memory during reset.
    always_comb begin
        w_gnt     = w_pick_gnt;
        w_win_idx = w_pick_idx;
        w_acc     = w_pick_any;
        if (r_state == LOCKED) begin
            w_gnt          = '0;
            w_gnt[r_owner] = req[r_owner];
            w_win_idx      = r_owner;
            w_acc          = req[r_owner];
        end
        if (!rst) begin
            w_gnt = '0;
            w_acc = 1'b0;
        end
    end

    // Winner attributes and the pointer value after it is served.
    always_comb begin
        w_win_we   = req_we[w_win_idx];
        w_win_lock = req_lock[w_win_idx];
        if (w_win_idx == IDX_W'(NUM_REQ - 1))
            w_ptr_nxt = '0;
        else
            w_ptr_nxt = w_win_idx + IDX_W'(1);
    end

    // Memory-side mux; address/data are zero when nothing is granted.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (w_acc) begin
            mem_addr  = req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[int'(w_win_idx)*DATA_W +: DATA_W];
            mem_we    = w_win_we;
        end
    end

    assign gnt    = w_gnt;
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;

    // Arbitration state: lock entry/exit and round-robin pointer advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB;
            r_ptr   <= '0;
            r_owner <= '0;
        end else if (w_acc) begin
            if (r_state == ARB) begin
                if (w_win_lock) begin
                    r_state <= LOCKED;
                    r_owner <= w_win_idx;
                end else begin
                    r_ptr <= w_ptr_nxt;
                end
            end else if (!w_win_lock) begin
                // Owner's final access releases; next requester gets priority.
                r_state <= ARB;
                r_ptr   <= w_ptr_nxt;
            end
        end
    end

    // Read return: capture memory data one cycle after an accepted read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= '0;
            if (w_acc && !w_win_we) begin
                r_rvalid <= w_gnt;
                r_rdata  <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    int                 w_req_cnt;
    logic [NUM_REQ-1:0] w_others;
    logic               w_conflict;

    // A conflict is contention in ARB, or anyone but the owner waiting.
    always_comb begin
        w_req_cnt = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_cnt = w_req_cnt + int'(req[i]);
        end
        w_others          = req;
        w_others[r_owner] = 1'b0;
        if (r_state == ARB)
            w_conflict = (w_req_cnt >= 2);
        else
            w_conflict = |w_others;
    end

    // Free-running statistics counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_grants    <= '0;
            stat_conflicts <= '0;
        end else begin
            if (w_acc)      stat_grants    <= stat_grants + 32'd1;
            if (w_conflict) stat_conflicts <= stat_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (NUM_REQ=2). A behavioural model of the
// arbitration rules and memory contents is compared against the DUT on every
// falling edge; the stimulus process adds literal expectations.
module tb_dmem_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req, req_we, req_lock;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      gnt, rvalid;
    logic [DW-1:0]        rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]        mem_addr;
    logic                 mem_we;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]          stat_grants, stat_conflicts;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    dmem_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
`ifdef DMEM_ARB_STATS_EN
        .stat_grants    (stat_grants),
        .stat_conflicts (stat_conflicts),
`endif
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory attached to the DUT, and an independent copy kept by the model.
    logic [31:0] mem [64];
    logic [31:0] mm  [64];
    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'hA000_0000 | i;
            mm[i]  = 32'hA000_0000 | i;
        end
    end
    always @(posedge clk) if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[5:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: priority pointer, lock, and the read result due next cycle.
    int          m_ptr   = 0;
    bit          m_lock  = 0;
    int          m_owner = 0;
    logic [1:0]  m_rv    = '0;
    logic [31:0] m_rd    = '0;

    always @(negedge clk) begin
        int          w;
        bit          v;
        logic [1:0]  eg;
        logic [31:0] ea, ed;
        if (!rst) begin
            chk("m_rst_gnt", gnt, 0);
            chk("m_rst_we", mem_we, 0);
            chk("m_rst_addr", mem_addr, 0);
            chk("m_rst_rvalid", rvalid, 0);
            chk("m_rst_rdata", rdata, 0);
            m_ptr = 0; m_lock = 0; m_owner = 0; m_rv = '0; m_rd = '0;
        end else begin
            v = 0; w = 0;
            if (m_lock) begin
                w = m_owner; v = req[w];
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    if (!v && req[(m_ptr + k) % NREQ]) begin
                        w = (m_ptr + k) % NREQ; v = 1;
                    end
                end
            end
            eg = v ? (2'b01 << w) : 2'b00;
            ea = v ? req_addr[w*AW +: AW] : 32'h0;
            ed = v ? req_wdata[w*DW +: DW] : 32'h0;
            chk("m_gnt", gnt, eg);
            chk("m_we", mem_we, v && req_we[w]);
            chk("m_addr", mem_addr, ea);
            chk("m_wdata", mem_wdata, ed);
            chk("m_rvalid", rvalid, m_rv);
            chk("m_rdata", rdata, m_rd);
            // Advance the model to what the coming rising edge does.
            m_rv = '0;
            if (v) begin
                if (req_we[w]) mm[ea[5:0]] = ed;
                else begin m_rv = eg; m_rd = mm[ea[5:0]]; end
                if (req_lock[w]) begin m_lock = 1; m_owner = w; end
                else begin m_lock = 0; m_ptr = (w + 1) % NREQ; end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic r, input logic we, input logic lk,
                           input logic [31:0] a, input logic [31:0] d);
        req[i]            = r;
        req_we[i]         = we;
        req_lock[i]       = lk;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] g0, c0;
`endif

    initial begin
        rst = 1'b0;
        req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        set_req(0, 1, 0, 0, 32'h4, 0);
        set_req(1, 1, 0, 0, 32'h8, 0);
        repeat (2) cyc();
        chk("rst_gnt", gnt, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);

        // Contention: alternating grants, reads returned one cycle later.
        rst = 1'b1;
        #2 chk("c0_gnt", gnt, 2'b01);
        cyc(); #2 chk("c1_gnt", gnt, 2'b10);
        chk("c1_rvalid", rvalid, 2'b01); chk("c1_rdata", rdata, 32'hA000_0004);
        cyc(); #2 chk("c2_gnt", gnt, 2'b01);
        chk("c2_rvalid", rvalid, 2'b10); chk("c2_rdata", rdata, 32'hA000_0008);
        cyc(); #2 chk("c3_gnt", gnt, 2'b10);
        chk("c3_rvalid", rvalid, 2'b01);
        cyc(); set_req(0, 0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0, 0);
        #2 chk("c4_rvalid", rvalid, 2'b10); chk("c4_rdata", rdata, 32'hA000_0008);

        // Write then read back by requester 1.
        cyc(); set_req(1, 1, 1, 0, 32'h5, 32'hDEAD_BEEF);
        #2 chk("wr_gnt", gnt, 2'b10); chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, 32'h5); chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        cyc(); set_req(1, 1, 0, 0, 32'h5, 0);
        #2 chk("rd_we", mem_we, 0); chk("rd_gnt", gnt, 2'b10);
        chk("wr_no_rvalid", rvalid, 2'b00);
        cyc(); set_req(1, 0, 0, 0, 0, 0);
        #2 chk("rd_rvalid", rvalid, 2'b10); chk("rd_rdata", rdata, 32'hDEAD_BEEF);

        // Lock held by requester 0 while requester 1 waits.
        cyc(); set_req(0, 1, 0, 1, 32'h3, 0); set_req(1, 1, 0, 0, 32'h8, 0);
        #2 chk("lk_gnt", gnt, 2'b01);
        repeat (3) begin
            cyc(); #2 chk("lk_hold_gnt", gnt, 2'b01);
            chk("lk_rvalid", rvalid, 2'b01); chk("lk_rdata", rdata, 32'hA000_0003);
        end
        cyc(); req[0] = 1'b0;
        #2 chk("lk_idle_gnt", gnt, 2'b00);
        cyc(); set_req(0, 1, 1, 0, 32'h3, 32'h1234_5678);
        #2 chk("lk_rel_gnt", gnt, 2'b01); chk("lk_rel_we", mem_we, 1);
        cyc(); set_req(0, 0, 0, 0, 0, 0);
        #2 chk("post_lk_gnt", gnt, 2'b10);
        cyc(); set_req(1, 0, 0, 0, 0, 0);
        #2 chk("post_lk_rdata", rdata, 32'hA000_0008);

        // Reset while locked with a read result outstanding.
        cyc(); set_req(0, 1, 0, 1, 32'h2, 0);
        #2 chk("rl_gnt", gnt, 2'b01);
        cyc(); set_req(1, 1, 0, 0, 32'h8, 0);
        chk("rl_rvalid_pre", rvalid, 2'b01);
        rst = 1'b0;
        #1 chk("rl_rvalid", rvalid, 2'b00); chk("rl_gnt", gnt, 2'b00);
        chk("rl_rdata", rdata, 0);
        req_lock[0] = 1'b0;
        cyc(); cyc(); rst = 1'b1;
        #2 chk("rl_arb_gnt", gnt, 2'b01);
        cyc(); #2 chk("rl_next_gnt", gnt, 2'b10);
        cyc(); #2 chk("wrap_gnt", gnt, 2'b01);
        cyc(); set_req(0, 0, 0, 0, 0, 0); set_req(1, 0, 0, 0, 0, 0);

`ifdef DMEM_ARB_STATS_EN
        cyc(); g0 = stat_grants; c0 = stat_conflicts;
        set_req(0, 1, 0, 0, 32'h10, 0); set_req(1, 1, 0, 0, 32'h11, 0);
        repeat (4) cyc();
        set_req(1, 0, 0, 0, 0, 0);
        repeat (2) cyc();
        set_req(0, 0, 0, 0, 0, 0);
        cyc();
        chk("stat_grants", stat_grants - g0, 32'd6);
        chk("stat_conflicts", stat_conflicts - c0, 32'd4);
`endif

        repeat (3) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory of the single-cycle core between NUM_REQ requesters, e.g. core load/store and a DMA/debug port.
- Each cycle: round-robin arbitration, one grant drives the memory address, write data and MemWrite; read data is registered and returned one cycle later with rvalid.
- Supports a lock so the granted requester can keep the memory for atomic read-modify-write.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- IDX_W, $clog2(NUM_REQ), grant index width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- req  in  NUM_REQ  per-requester access request
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  hold grant after this access
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted access
- rvalid  out  NUM_REQ  one-hot read-data valid, one cycle after a granted read
- rdata  out  DATA_W  registered read data, shared by all requesters
- mem_addr  out  ADDR_W  to data memory addr
- mem_wdata  out  DATA_W  to data memory wdata
- mem_we  out  1  to data memory MemWrite
- mem_rdata  in  DATA_W  from data memory rdata (combinational read)

Behaviour:
- Reset (rst=0, async): ptr=0, state=ARB, owner=0, rvalid=0, rdata=0. While in reset, gnt=0 and mem_we=0 regardless of req. mem_addr/mem_wdata = 0 when no grant.
- Access is accepted in a cycle when req[i] & gnt[i]. The requester holds req, addr, we and wdata stable until granted; unaccepted requests are never dropped.
- ARB state:
  - Winner is the first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - gnt = onehot(winner). mem_addr/mem_wdata come from the winner; mem_we = req_we[winner].
  - With no req, gnt=0 and mem_we=0.
  - On acceptance without lock: ptr <= (winner+1) mod NUM_REQ.
  - On acceptance with req_lock[winner]=1: state <= LOCKED, owner <= winner; ptr unchanged.
- LOCKED state:
  - Only owner can be granted; gnt[owner] = req[owner]; other requesters wait.
  - An access by owner with req_lock=0 releases: state <= ARB, ptr <= (owner+1) mod NUM_REQ.
  - Owner deasserting req while locked keeps the lock (idle hold, no timeout).
- Reads: on an accepted read, rdata <= mem_rdata and rvalid <= onehot(winner) at the next edge. Otherwise rvalid <= 0 and rdata holds. Latency is exactly 1 cycle; back-to-back reads give a rvalid every cycle.
- Writes: mem_we is high exactly in the accept cycle; no rvalid for writes.
- Simultaneous requests: only one granted per cycle; the loser stays pending and is granted next cycle if ptr now favours it.
- Wrap-around: ptr from NUM_REQ-1 advances to 0.
- Reset mid-lock returns to ARB, ptr=0; a pending rvalid is cleared.
- Address is passed through unmodified; range checking is done by the memory.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_grants (32 bits, accepted accesses) and stat_conflicts (32 bits, cycles with ≥2 req high in ARB, or any non-owner req high in LOCKED). Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; arbitration behaviour identical.

Decomposition:
- Shared package dmem_pkg: arbiter state enum (ARB, LOCKED), default ADDR_W/DATA_W constants, function rr_pick(req, ptr) returning the winner index.
- One sub-module is natural: dmem_rr_pick, a pure combinational round-robin picker (req, ptr -> gnt onehot, idx, any). It is reused by future bus arbiters.

Test Plan:
- Reset: rst=0 with req=2'b11 -> gnt=0, mem_we=0, rvalid=0, rdata=0. Release rst -> req0 granted first (ptr=0).
- Contention: req=2'b11 held for 4 cycles, reads to 0x4/0x8 -> gnt 01,10,01,10. rvalid follows one cycle later with rdata=mem[addr].
- Write then read: req1 writes 0xDEADBEEF to addr 5 (mem_we pulse 1 cycle), then reads 5 -> next cycle rvalid=2'b10, rdata=0xDEADBEEF.
- Lock: req0 reads addr 3 with lock=1 while req1 pending 3 cycles -> gnt stays 01. Req0 writes addr 3 with lock=0 -> next cycle gnt=10.
- Reset mid-lock: rst=0 during LOCKED with a read rvalid pending -> rvalid=0 immediately. After release, ARB with ptr=0.
- Stats (with DMEM_ARB_STATS_EN): 4 contended cycles + 2 solo -> stat_grants=6, stat_conflicts=4.
